// File: rtl/matrix_scan_decoder.sv
// matrix_scan_decoder: captures an 8x8 LED matrix from a column-scanned bus and decodes a pair
// of active-low 7-segment digits into BCD and binary.
//
// Ports:
//   clk, rst_n     - clock; asynchronous active-low reset
//   sample_en      - sample row/col this cycle and advance the frame counter
//   row, col       - row data for the one-hot column selected by col
//   tens, units    - active-low 7-segment codes, decoded every cycle
//   frame_ready    - consumer accepts frame_data
//   frame_data     - captured frame, column k at [8k+7:8k]
//   frame_valid    - frame_data holds an unconsumed frame
//   frame_overrun  - sticky: an unconsumed frame was overwritten
//   bad_col_cnt    - saturating count of non-one-hot col samples
//   score_bcd      - {tens, units} BCD digits
//   score_bin      - tens*10 + units
//   score_blank    - a digit input carries the blank code
//   score_err      - a digit input carries an illegal code
module matrix_scan_decoder #(
  parameter int unsigned FRAME_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_en,
  input  logic [7:0]  row,
  input  logic [7:0]  col,
  input  logic [7:0]  tens,
  input  logic [7:0]  units,
  input  logic        frame_ready,
  output logic [63:0] frame_data,
  output logic        frame_valid,
  output logic        frame_overrun,
  output logic [7:0]  bad_col_cnt,
  output logic [7:0]  score_bcd,
  output logic [6:0]  score_bin,
  output logic        score_blank,
  output logic        score_err
);

  localparam logic [7:0] LastCnt = 8'(FRAME_CYCLES - 1);

  // Returns {err, blank, digit}.
  function automatic logic [5:0] seg_decode(input logic [7:0] code);
    logic [5:0] res;
    res = 6'b000000;
    case (code)
      8'hC0:   res[3:0] = 4'd0;
      8'hF9:   res[3:0] = 4'd1;
      8'hA4:   res[3:0] = 4'd2;
      8'hB0:   res[3:0] = 4'd3;
      8'h99:   res[3:0] = 4'd4;
      8'h92:   res[3:0] = 4'd5;
      8'h82:   res[3:0] = 4'd6;
      8'hF8:   res[3:0] = 4'd7;
      8'h80:   res[3:0] = 4'd8;
      8'h90:   res[3:0] = 4'd9;
      8'hFF:   res[4]   = 1'b1;
      default: res[5]   = 1'b1;
    endcase
    return res;
  endfunction

  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] shadow_q, shadow_d;
  logic [63:0] frame_data_q, frame_data_d;
  logic        frame_valid_q, frame_valid_d;
  logic        frame_overrun_q, frame_overrun_d;
  logic [7:0]  bad_col_cnt_q, bad_col_cnt_d;
  logic [7:0]  score_bcd_q, score_bcd_d;
  logic [6:0]  score_bin_q, score_bin_d;
  logic        score_blank_q, score_blank_d;
  logic        score_err_q, score_err_d;

  logic        col_onehot;
  logic        complete;
  logic [63:0] contrib;
  logic [63:0] merged;
  logic [5:0]  tens_dec, units_dec;

  always_comb begin
    col_onehot = (col != 8'h00) && ((col & (col - 8'h01)) == 8'h00);
    for (int k = 0; k < 8; k++) begin
      contrib[8*k +: 8] = (sample_en && col_onehot && col[k]) ? row : 8'h00;
    end
    complete = sample_en && (cnt_q == LastCnt);
    // The completing sample's own contribution belongs to the frame being closed.
    merged   = shadow_q | contrib;

    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    if (sample_en) begin
      if (complete) begin
        cnt_d    = 8'h00;
        shadow_d = '0;
      end else begin
        cnt_d    = cnt_q + 8'h01;
        shadow_d = merged;
      end
    end

    frame_data_d    = complete ? merged : frame_data_q;
    frame_valid_d   = complete || (frame_valid_q && !frame_ready);
    frame_overrun_d = frame_overrun_q || (complete && frame_valid_q && !frame_ready);

    bad_col_cnt_d = bad_col_cnt_q;
    if (sample_en && !col_onehot && (bad_col_cnt_q != 8'hFF)) begin
      bad_col_cnt_d = bad_col_cnt_q + 8'h01;
    end

    tens_dec      = seg_decode(tens);
    units_dec     = seg_decode(units);
    score_bcd_d   = {tens_dec[3:0], units_dec[3:0]};
    score_bin_d   = 7'(tens_dec[3:0]) * 7'd10 + 7'(units_dec[3:0]);
    score_blank_d = tens_dec[4] | units_dec[4];
    score_err_d   = tens_dec[5] | units_dec[5];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q           <= 8'h00;
      shadow_q        <= '0;
      frame_data_q    <= '0;
      frame_valid_q   <= 1'b0;
      frame_overrun_q <= 1'b0;
      bad_col_cnt_q   <= 8'h00;
      score_bcd_q     <= 8'h00;
      score_bin_q     <= 7'h00;
      score_blank_q   <= 1'b0;
      score_err_q     <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      shadow_q        <= shadow_d;
      frame_data_q    <= frame_data_d;
      frame_valid_q   <= frame_valid_d;
      frame_overrun_q <= frame_overrun_d;
      bad_col_cnt_q   <= bad_col_cnt_d;
      score_bcd_q     <= score_bcd_d;
      score_bin_q     <= score_bin_d;
      score_blank_q   <= score_blank_d;
      score_err_q     <= score_err_d;
    end
  end

  assign frame_data    = frame_data_q;
  assign frame_valid   = frame_valid_q;
  assign frame_overrun = frame_overrun_q;
  assign bad_col_cnt   = bad_col_cnt_q;
  assign score_bcd     = score_bcd_q;
  assign score_bin     = score_bin_q;
  assign score_blank   = score_blank_q;
  assign score_err     = score_err_q;

endmodule

// File: tb/tb_matrix_scan_decoder.sv
// Directed bench for matrix_scan_decoder with a frame-level reference model checked every cycle.
module tb_matrix_scan_decoder;

  localparam int unsigned N = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_en = 1'b0;
  logic        frame_ready = 1'b0;
  logic [7:0]  row = 8'h00;
  logic [7:0]  col = 8'h00;
  logic [7:0]  tens = 8'hC0;
  logic [7:0]  units = 8'hC0;
  logic [63:0] frame_data;
  logic        frame_valid;
  logic        frame_overrun;
  logic [7:0]  bad_col_cnt;
  logic [7:0]  score_bcd;
  logic [6:0]  score_bin;
  logic        score_blank;
  logic        score_err;

  matrix_scan_decoder #(.FRAME_CYCLES(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_en    (sample_en),
    .row          (row),
    .col          (col),
    .tens         (tens),
    .units        (units),
    .frame_ready  (frame_ready),
    .frame_data   (frame_data),
    .frame_valid  (frame_valid),
    .frame_overrun(frame_overrun),
    .bad_col_cnt  (bad_col_cnt),
    .score_bcd    (score_bcd),
    .score_bin    (score_bin),
    .score_blank  (score_blank),
    .score_err    (score_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  function automatic void decode(input logic [7:0] code, output int d, output bit blank,
                                 output bit err);
    d = 0; blank = 0; err = 1;
    if (code == 8'hFF) begin
      blank = 1; err = 0;
    end
    for (int i = 0; i < 10; i++) begin
      if (seg_tab[i] == code) begin
        d = i; err = 0;
      end
    end
  endfunction

  logic [7:0]  m_cols [8];
  int          m_nsamp;
  logic [63:0] m_frame;
  logic        m_valid, m_ovr;
  int          m_bad;
  logic [7:0]  m_bcd;
  int          m_bin;
  logic        m_blank, m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) m_cols[k] <= 8'h00;
      m_nsamp <= 0; m_frame <= '0; m_valid <= 0; m_ovr <= 0; m_bad <= 0;
      m_bcd <= 8'h00; m_bin <= 0; m_blank <= 0; m_err <= 0;
    end else begin : model_step
      logic [7:0]  c [8];
      logic [63:0] f;
      int          td, ud;
      bit          tbl, terr, ubl, uerr;
      logic        v;
      decode(tens, td, tbl, terr);
      decode(units, ud, ubl, uerr);
      m_bcd   <= {td[3:0], ud[3:0]};
      m_bin   <= td * 10 + ud;
      m_blank <= tbl | ubl;
      m_err   <= terr | uerr;
      v = m_valid && !frame_ready;
      for (int k = 0; k < 8; k++) c[k] = m_cols[k];
      if (sample_en) begin
        if ($countones(col) == 1) begin
          for (int k = 0; k < 8; k++) if (col[k]) c[k] = c[k] | row;
        end else if (m_bad < 255) begin
          m_bad <= m_bad + 1;
        end
        if (m_nsamp + 1 == N) begin
          for (int k = 0; k < 8; k++) f[8*k +: 8] = c[k];
          m_frame <= f;
          if (m_valid && !frame_ready) m_ovr <= 1;
          v = 1;
          for (int k = 0; k < 8; k++) c[k] = 8'h00;
          m_nsamp <= 0;
        end else begin
          m_nsamp <= m_nsamp + 1;
        end
      end
      m_valid <= v;
      for (int k = 0; k < 8; k++) m_cols[k] <= c[k];
    end
  end

  always @(negedge clk) begin
    chk("cyc.frame_data", frame_data, m_frame);
    chk("cyc.frame_valid", 64'(frame_valid), 64'(m_valid));
    chk("cyc.frame_overrun", 64'(frame_overrun), 64'(m_ovr));
    chk("cyc.bad_col_cnt", 64'(bad_col_cnt), 64'(m_bad));
    chk("cyc.score_bcd", 64'(score_bcd), 64'(m_bcd));
    chk("cyc.score_bin", 64'(score_bin), 64'(m_bin));
    chk("cyc.score_blank", 64'(score_blank), 64'(m_blank));
    chk("cyc.score_err", 64'(score_err), 64'(m_err));
  end

  // ---------------- directed stimulus ----------------
  // Applies inputs, lets one rising edge pass, returns 2 ns after it.
  task automatic smp(input logic en, input logic [7:0] c, input logic [7:0] r, input logic rdy);
    sample_en = en; col = c; row = r; frame_ready = rdy;
    @(posedge clk);
    #2;
  endtask

  // Short reset pulse away from any clock edge.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #12 rst_n = 1'b1;
    chk("reset.frame_valid", 64'(frame_valid), 64'd0);
    chk("reset.frame_data", frame_data, 64'd0);
    chk("reset.bad_col_cnt", 64'(bad_col_cnt), 64'd0);
    smp(1'b0, 8'h00, 8'h00, 1'b0);
    chk("idle.score_bcd", 64'(score_bcd), 64'h00);

    // Rotating columns, all C7.
    for (int i = 0; i < 16; i++) begin
      smp(1'b1, 8'(1 << (i % 8)), 8'hC7, 1'b0);
      if (i == 14) chk("rot.valid_before_last", 64'(frame_valid), 64'd0);
    end
    chk("rot.frame_valid", 64'(frame_valid), 64'd1);
    chk("rot.frame_data", frame_data, {8{8'hC7}});
    chk("rot.model_frame", m_frame, {8{8'hC7}});

    smp(1'b0, 8'h00, 8'h00, 1'b1);
    chk("consume.frame_valid", 64'(frame_valid), 64'd0);

    // Alternating two columns.
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) smp(1'b1, 8'h80, 8'hC7, 1'b0);
      else            smp(1'b1, 8'h02, 8'h08, 1'b0);
    end
    chk("alt.frame_data", frame_data, 64'hC700_0000_0000_0800);
    chk("alt.frame_overrun", 64'(frame_overrun), 64'd0);

    // Second frame, not consumed: overrun.
    for (int i = 0; i < 16; i++) smp(1'b1, 8'(1 << (i % 8)), (i < 8) ? 8'h10 : 8'h01, 1'b0);
    chk("ovr.frame_overrun", 64'(frame_overrun), 64'd1);
    chk("ovr.frame_data", frame_data, {8{8'h11}});
    chk("ovr.frame_valid", 64'(frame_valid), 64'd1);

    // Completion coinciding with a consume: no overrun.
    pulse_reset();
    chk("rst.frame_overrun", 64'(frame_overrun), 64'd0);
    for (int i = 0; i < 16; i++) smp(1'b1, 8'h01, 8'hAA, 1'b0);
    for (int i = 0; i < 15; i++) smp(1'b1, 8'h80, 8'h55, 1'b0);
    smp(1'b1, 8'h80, 8'h55, 1'b1);
    chk("hs.frame_valid", 64'(frame_valid), 64'd1);
    chk("hs.frame_overrun", 64'(frame_overrun), 64'd0);
    chk("hs.frame_data", frame_data, 64'h5500_0000_0000_0000);

    // Invalid column selects and saturation.
    pulse_reset();
    smp(1'b1, 8'h00, 8'hFF, 1'b0);
    chk("bad.zero", 64'(bad_col_cnt), 64'd1);
    smp(1'b1, 8'h03, 8'hFF, 1'b0);
    chk("bad.multi", 64'(bad_col_cnt), 64'd2);
    for (int i = 0; i < 300; i++) smp(1'b1, (i % 2 == 1) ? 8'h00 : 8'hF0, 8'hFF, 1'b0);
    chk("bad.saturate", 64'(bad_col_cnt), 64'd255);
    chk("bad.frame_data", frame_data, 64'd0);

    // Digit decode.
    tens = 8'hA4; units = 8'h90;
    smp(1'b0, 8'h00, 8'h00, 1'b1);
    chk("dig.bcd29", 64'(score_bcd), 64'h29);
    chk("dig.bin29", 64'(score_bin), 64'd29);
    chk("dig.blank0", 64'(score_blank), 64'd0);
    tens = 8'hFF;
    smp(1'b0, 8'h00, 8'h00, 1'b1);
    chk("dig.blank1", 64'(score_blank), 64'd1);
    chk("dig.bcd09", 64'(score_bcd), 64'h09);
    tens = 8'hA4; units = 8'h12;
    smp(1'b0, 8'h00, 8'h00, 1'b1);
    chk("dig.err1", 64'(score_err), 64'd1);
    chk("dig.bin20", 64'(score_bin), 64'd20);

    // Short reset mid-frame.
    units = 8'h90;
    for (int i = 0; i < 5; i++) smp(1'b1, 8'(1 << i), 8'h3C, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("pulse.frame_data", frame_data, 64'd0);
    chk("pulse.flags", {frame_valid, frame_overrun, score_blank, score_err}, 64'd0);
    chk("pulse.bad_col_cnt", 64'(bad_col_cnt), 64'd0);
    chk("pulse.score", {score_bcd, 1'b0, score_bin}, 64'd0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 15; i++) smp(1'b1, 8'h04, 8'h81, 1'b0);
    chk("pulse.valid_early", 64'(frame_valid), 64'd0);
    smp(1'b1, 8'h04, 8'h81, 1'b0);
    chk("pulse.valid", 64'(frame_valid), 64'd1);
    chk("pulse.frame_data", frame_data, 64'h0000_0000_0081_0000);

    smp(1'b0, 8'h00, 8'h00, 1'b1);
    smp(1'b0, 8'h00, 8'h00, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
